dds_serial_port: RTL

Serial register-port master for the DDS chip, sitting directly downstream of `controller`. It accepts one register transaction per `wr_start` request (8-bit instruction `wr_addr`, 32-bit word `wr_data`) and shifts it out MSB-first on a 4-wire serial bus. Reads capture the returned word into `wr_out`. Writes finish with an I/O_UPDATE pulse. Completion is signalled to `controller` with a one-cycle `wr_done`.

---
 rtl/dds_serial_port_if.sv | 26 ++
 rtl/dds_serial_port.sv | 98 +++++++++
 2 files changed

// File: rtl/dds_serial_port_if.sv
// Register-port bundle between controller and the DDS serial master.
// master: controller side (plus the chip's SDO return line).
// slave:  the serial port block itself.
interface dds_serial_port_if;
  logic        wr_start;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_done;
  logic [31:0] wr_out;
  logic        busy;
  logic        SCLK;
  logic        CS_N;
  logic        SDIO;
  logic        SDO;
  logic        IO_UPDATE;

  modport master (
    output wr_start, wr_addr, wr_data, SDO,
    input  wr_done, wr_out, busy, SCLK, CS_N, SDIO, IO_UPDATE
  );

  modport slave (
    input  wr_start, wr_addr, wr_data, SDO,
    output wr_done, wr_out, busy, SCLK, CS_N, SDIO, IO_UPDATE
  );
endinterface

// File: rtl/dds_serial_port.sv
// DDS serial register-port master: shifts a 40-bit {instruction, word}
// frame MSB-first, captures the read word from SDO, and strobes
// IO_UPDATE after writes.
module dds_serial_port #(
  parameter int CLK_DIV     = 2,
  parameter int IOUP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  dds_serial_port_if.slave  bus
);
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int IW = $clog2(IOUP_CYCLES) + 1;
  localparam logic [DW-1:0] DIV_RISE = DW'(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [IW-1:0] IOU_LAST = IW'(IOUP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, IOUP, DONE} state_t;

  state_t         state, state_nxt;
  logic [39:0]    sreg;
  logic [5:0]     bit_cnt;
  logic [DW-1:0]  div_cnt;
  logic [IW-1:0]  iou_cnt;
  logic [31:0]    cap, cap_nxt, wr_out_q;
  logic           is_rd;
  logic           load, bit_end, sclk_rise, last_bit;

  // Bit-period decode: div_cnt runs 0..2*CLK_DIV-1, low half then high half.
  assign bit_end   = (state == SHIFT) && (div_cnt == DIV_LAST);
  assign sclk_rise = (state == SHIFT) && (div_cnt == DIV_RISE);
  assign last_bit  = bit_end && (bit_cnt == 6'd39);

  // Capture only the 32 data bits; next-value form lets wr_out pick up the
  // final bit on the same edge even when CLK_DIV=1.
  assign cap_nxt = (sclk_rise && is_rd && bit_cnt >= 6'd8) ? {cap[30:0], bus.SDO} : cap;

  // Serial pins and status are decoded straight from registered state.
  assign bus.CS_N      = (state != SHIFT);
  assign bus.SCLK      = (state == SHIFT) && (div_cnt >= DIV_RISE);
  assign bus.SDIO      = (state == SHIFT) ? sreg[39] : 1'b0;
  assign bus.IO_UPDATE = (state == IOUP);
  assign bus.wr_done   = (state == DONE);
  assign bus.busy      = (state == SHIFT) || (state == IOUP);
  assign bus.wr_out    = wr_out_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and frame-load decision; DONE accepts a new request directly.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE:  if (bus.wr_start) begin load = 1'b1; state_nxt = SHIFT; end
      SHIFT: if (last_bit) state_nxt = is_rd ? DONE : IOUP;
      IOUP:  if (iou_cnt == IOU_LAST) state_nxt = DONE;
      DONE:  begin
        if (bus.wr_start) begin load = 1'b1; state_nxt = SHIFT; end
        else state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift datapath, counters and read capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg     <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      iou_cnt  <= '0;
      cap      <= '0;
      is_rd    <= 1'b0;
      wr_out_q <= '0;
    end else begin
      cap <= cap_nxt;
      if (load) begin
        sreg    <= {bus.wr_addr, bus.wr_data};
        is_rd   <= bus.wr_addr[7];
        bit_cnt <= '0;
        div_cnt <= '0;
        cap     <= '0;
      end else if (state == SHIFT) begin
        div_cnt <= bit_end ? '0 : div_cnt + DW'(1);
        if (bit_end) begin
          sreg <= {sreg[38:0], 1'b0};
          if (bit_cnt != 6'd39) bit_cnt <= bit_cnt + 6'd1;
        end
      end
      iou_cnt <= (state == IOUP) ? iou_cnt + IW'(1) : '0;
      if (last_bit && is_rd) wr_out_q <= cap_nxt;
    end
  end
endmodule
